// File: rtl/uart_tx_flow_sched.sv
// rtl/uart_tx_flow_sched.sv - RTS/CTS flow-controlled TX FIFO to UART transmitter sequencer
//
// Purpose: drains the TX FIFO one byte per frame into the UART transmitter,
// gated by synchronized CTS, with a fixed inter-frame guard gap and a sticky
// CTS timeout flag.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   enable               TX enable from the register block
//   timeout_limit        CTS wait limit in clk cycles (0 = no timeout)
//   timeout_clr          pulse, clears cts_timeout
//   fifo_empty           TX FIFO empty
//   fifo_rd_data         TX FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en           one-cycle FIFO pop
//   tx_data              byte presented to the transmitter
//   tx_start             one-cycle frame start pulse
//   tx_busy              transmitter busy
//   cts_n                asynchronous active-low Clear-To-Send
//   rts_n                active-low Request-To-Send
//   cts_timeout          sticky CTS timeout flag
//   active               high whenever the sequencer is not idle
module uart_tx_flow_sched #(
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 timeout_clr,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    input  logic                 cts_n,
    output logic                 rts_n,
    output logic                 cts_timeout,
    output logic                 active
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CTS,
        S_FETCH,
        S_LOAD,
        S_START,
        S_SEND,
        S_GAP
    } state_t;

    state_t state, next_state;

    logic                 cts_meta, cts_sync, cts_ok;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 seen_busy;
    logic                 can_start, timeout_fire, frame_done, gap_done;
    logic                 fifo_rd_en_d, tx_start_d, rts_n_d, active_d;

    // Synchronizer resets to "not clear" so nothing starts before CTS is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok       = ~cts_sync;
    assign can_start    = enable & ~fifo_empty & ~cts_timeout;
    // Only reachable with enable high and CTS low, so it never competes with FETCH.
    assign timeout_fire = (state == S_WAIT_CTS) & enable & ~cts_ok &
                          (timeout_limit != '0) &
                          (wait_cnt == timeout_limit - TIMEOUT_W'(1));
    assign frame_done   = seen_busy & ~tx_busy;
    assign gap_done     = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (can_start) next_state = S_WAIT_CTS;
            S_WAIT_CTS: begin
                if (!enable)                 next_state = S_IDLE;
                else if (cts_ok && !tx_busy) next_state = S_FETCH;
                else if (timeout_fire)       next_state = S_IDLE;
            end
            S_FETCH:    next_state = S_LOAD;
            S_LOAD:     next_state = S_START;
            S_START:    next_state = S_SEND;
            S_SEND: begin
                if (frame_done) begin
                    if (GAP_CYCLES == 0) next_state = can_start ? S_WAIT_CTS : S_IDLE;
                    else                 next_state = S_GAP;
                end
            end
            S_GAP:      if (gap_done) next_state = can_start ? S_WAIT_CTS : S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so each one is
    // valid for exactly the cycle spent in the corresponding state.
    always_comb begin
        fifo_rd_en_d = (next_state == S_FETCH);
        tx_start_d   = (next_state == S_START);
        active_d     = (next_state != S_IDLE);
        rts_n_d      = 1'b1;
        case (next_state)
            S_WAIT_CTS, S_FETCH, S_LOAD, S_START, S_SEND: rts_n_d = 1'b0;
            S_GAP:   rts_n_d = ~(enable & ~fifo_empty);
            default: rts_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            rts_n      <= 1'b1;
            active     <= 1'b0;
        end else begin
            fifo_rd_en <= fifo_rd_en_d;
            tx_start   <= tx_start_d;
            rts_n      <= rts_n_d;
            active     <= active_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data     <= 8'h00;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            seen_busy   <= 1'b0;
            cts_timeout <= 1'b0;
        end else begin
            if (state == S_LOAD) tx_data <= fifo_rd_data;

            // Held at zero on entry; counts only cycles spent waiting on CTS.
            if (next_state != S_WAIT_CTS)                  wait_cnt <= '0;
            else if (state == S_WAIT_CTS && !cts_ok)        wait_cnt <= wait_cnt + TIMEOUT_W'(1);

            if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                gap_cnt <= '0;

            if (state == S_SEND) begin
                if (tx_busy) seen_busy <= 1'b1;
            end else begin
                seen_busy <= 1'b0;
            end

            // Set has priority over a coincident clear.
            if (timeout_fire)     cts_timeout <= 1'b1;
            else if (timeout_clr) cts_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_flow_sched.sv
// tb/tb_uart_tx_flow_sched.sv - directed self-checking bench for uart_tx_flow_sched
module tb_uart_tx_flow_sched;

    localparam int GAP      = 16;
    localparam int TW       = 16;
    localparam int BUSY_LEN = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [TW-1:0] timeout_limit;
    logic          timeout_clr;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data = 8'h00;
    logic          fifo_rd_en;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          cts_n;
    logic          rts_n;
    logic          cts_timeout;
    logic          active;

    uart_tx_flow_sched #(.GAP_CYCLES(GAP), .TIMEOUT_W(TW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .timeout_limit (timeout_limit),
        .timeout_clr   (timeout_clr),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .cts_n         (cts_n),
        .rts_n         (rts_n),
        .cts_timeout   (cts_timeout),
        .active        (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] fifo_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    int         n_rden   = 0;
    int         n_starts = 0;
    int         n_falls  = 0;
    int         rts_viol = 0;
    int         busy_cnt = 0;
    logic [7:0] start_data [0:31];
    int         start_cyc  [0:31];
    int         fall_cyc   [0:31];

    // FIFO and transmitter models act on the falling edge, away from the DUT edge.
    always @(negedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            n_rden       <= n_rden + 1;
            fifo_rd_data <= fifo_mem[rd_ptr[5:0]];
            rd_ptr       <= rd_ptr + 1;
        end
        if (!reset_n) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            start_data[n_starts[4:0]] <= tx_data;
            start_cyc[n_starts[4:0]]  <= cyc;
            n_starts <= n_starts + 1;
            tx_busy  <= 1'b1;
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                tx_busy <= 1'b0;
                fall_cyc[n_falls[4:0]] <= cyc;
                n_falls <= n_falls + 1;
            end
        end
        if (reset_n && tx_busy && rts_n) rts_viol <= rts_viol + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_starts < target; i++) tick(1);
        check(tag, n_starts, target);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && active; i++) tick(1);
        check(tag, {31'd0, active}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_en"},   {31'd0, fifo_rd_en},  32'd0);
        check({pfx, "_start"},   {31'd0, tx_start},    32'd0);
        check({pfx, "_tx_data"}, {24'd0, tx_data},     32'h00);
        check({pfx, "_rts_n"},   {31'd0, rts_n},       32'd1);
        check({pfx, "_timeout"}, {31'd0, cts_timeout}, 32'd0);
        check({pfx, "_active"},  {31'd0, active},      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int base, p, t, a, r, r0, q;

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        timeout_clr   = 1'b0;
        cts_n         = 1'b1;
        timeout_limit = '0;
        tick(3);
        check_reset_outputs("reset");

        reset_n = 1'b1;
        cts_n   = 1'b0;
        enable  = 1'b1;
        tick(5);

        // Single byte
        push(8'hA5);
        p = cyc;
        wait_starts(1, 20, "single_start");
        wait_idle(100, "single_idle");
        check("single_pops", n_rden, 1);
        check("single_data", {24'd0, start_data[0]}, 32'hA5);
        check("single_latency", start_cyc[0] - p, 4);
        check("single_tx_data", {24'd0, tx_data}, 32'hA5);
        check("single_rts_after", {31'd0, rts_n}, 32'd1);

        // Burst of three
        base = n_starts;
        push(8'h01); push(8'h02); push(8'h03);
        p = cyc;
        wait_starts(base + 3, 200, "burst_starts");
        wait_idle(100, "burst_idle");
        check("burst_latency", start_cyc[5'(base)] - p, 4);
        for (int i = 0; i < 3; i++)
            check("burst_data", {24'd0, start_data[5'(base + i)]}, i + 1);
        for (int i = 1; i < 3; i++)
            check("burst_gap", start_cyc[5'(base + i)] - fall_cyc[5'(base + i - 1)], GAP + 4);

        // CTS withheld -> timeout
        cts_n         = 1'b1;
        timeout_limit = TW'(100);
        tick(4);
        r0 = n_rden;
        base = n_starts;
        push(8'h55);
        p = cyc;
        for (int i = 0; i < 150 && !cts_timeout; i++) tick(1);
        t = cyc;
        check("to_flag", {31'd0, cts_timeout}, 32'd1);
        check("to_latency", t - p, 101);
        check("to_no_pop", n_rden, r0);
        tick(5);
        check("to_idle", {31'd0, active}, 32'd0);
        check("to_rts", {31'd0, rts_n}, 32'd1);

        // Clear restarts the wait; a clear coinciding with the set loses
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        for (int i = 0; i < 10 && !active; i++) tick(1);
        a = cyc;
        check("to_restart", {31'd0, active}, 32'd1);
        tick(99);
        check("to_not_early", {31'd0, cts_timeout}, 32'd0);
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        check("to_set_wins", {31'd0, cts_timeout}, 32'd1);
        check("to_no_pop2", n_rden, r0);

        cts_n         = 1'b0;
        timeout_limit = '0;
        tick(3);
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        wait_starts(base + 1, 30, "to_resume");
        check("to_resume_data", {24'd0, start_data[5'(base)]}, 32'h55);
        wait_idle(100, "to_resume_idle");

        // CTS dropped mid-frame
        base = n_starts;
        push(8'h66); push(8'h77);
        wait_starts(base + 1, 20, "cd_first");
        cts_n = 1'b1;
        tick(60);
        check("cd_frame_done", n_falls, base + 1);
        check("cd_stalled", n_starts, base + 1);
        check("cd_wait_active", {31'd0, active}, 32'd1);
        check("cd_rts", {31'd0, rts_n}, 32'd0);
        cts_n = 1'b0;
        r = cyc;
        wait_starts(base + 2, 20, "cd_second");
        check("cd_latency", start_cyc[5'(base + 1)] - r, 5);
        check("cd_data0", {24'd0, start_data[5'(base)]}, 32'h66);
        check("cd_data1", {24'd0, start_data[5'(base + 1)]}, 32'h77);
        wait_idle(100, "cd_idle");

        // Enable dropped in WAIT_CTS
        cts_n = 1'b1;
        tick(3);
        r0 = n_rden;
        base = n_starts;
        push(8'h88);
        tick(5);
        check("enw_active", {31'd0, active}, 32'd1);
        enable = 1'b0;
        tick(3);
        check("enw_idle", {31'd0, active}, 32'd0);
        check("enw_no_pop", n_rden, r0);
        enable = 1'b1;
        cts_n  = 1'b0;
        wait_starts(base + 1, 20, "enw_resume");
        check("enw_data", {24'd0, start_data[5'(base)]}, 32'h88);
        wait_idle(100, "enw_resume_idle");

        // Enable dropped in SEND
        base = n_starts;
        r0 = n_rden;
        push(8'h99); push(8'hAA);
        wait_starts(base + 1, 20, "ens_start");
        enable = 1'b0;
        wait_idle(100, "ens_idle");
        check("ens_frame_done", n_falls, base + 1);
        check("ens_pops", n_rden - r0, 1);
        check("ens_fifo_left", wr_ptr - rd_ptr, 1);
        enable = 1'b1;
        wait_starts(base + 2, 20, "ens_resume");
        check("ens_data", {24'd0, start_data[5'(base + 1)]}, 32'hAA);
        wait_idle(100, "ens_resume_idle");

        // Reset asserted in SEND
        base = n_starts;
        push(8'hBB);
        wait_starts(base + 1, 20, "rst_first");
        tick(3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        push(8'hCC);
        tick(2);
        r0 = n_rden;
        q = cyc;
        reset_n = 1'b1;
        wait_starts(base + 2, 20, "rst_resume");
        check("rst_latency", start_cyc[5'(base + 1)] - q, 5);
        check("rst_data", {24'd0, start_data[5'(base + 1)]}, 32'hCC);
        check("rst_pops", n_rden - r0, 1);
        wait_idle(100, "rst_idle");

        check("rts_during_frames", rts_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
